// File: rtl/ula_seq.sv
// ula_seq: registered ALU with valid/ready handshakes on both sides.
// Single-cycle logic/arithmetic ops, one-bit-per-cycle variable shifts and,
// when ULA_MUL_EN is defined, an iterative unsigned shift-add multiplier.
// Every accepted command spends at least one EXEC cycle, so the result
// registers always load from captured operands and never from live inputs.
module ula_seq #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic [3:0]       seletor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] resultado,
  output logic [WIDTH-1:0] resultado_hi,
  output logic             Cout,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);

  localparam int unsigned SW = $clog2(WIDTH);
  localparam int unsigned CW = $clog2(WIDTH + 1);

  localparam logic [3:0] OpAnd  = 4'h0;
  localparam logic [3:0] OpOr   = 4'h1;
  localparam logic [3:0] OpNot  = 4'h2;
  localparam logic [3:0] OpNand = 4'h3;
  localparam logic [3:0] OpAdd  = 4'h4;
  localparam logic [3:0] OpSub  = 4'h5;
  localparam logic [3:0] OpShl1 = 4'h6;
  localparam logic [3:0] OpShr1 = 4'h7;
  localparam logic [3:0] OpXor  = 4'h8;
  localparam logic [3:0] OpSra1 = 4'h9;
  localparam logic [3:0] OpShlV = 4'hA;
  localparam logic [3:0] OpShrV = 4'hB;
  localparam logic [3:0] OpMul  = 4'hC;

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] a_q, b_q, sh_q, res_q;
  logic [3:0]       op_q;
  logic [CW-1:0]    cnt_q, cnt_load;
  logic             cin_q, shc_q, cout_q, zero_q, neg_q, ovf_q;
  logic             accept, last, is_var_in, is_mul_in;

  logic [WIDTH:0]   sum, diff;
  logic [WIDTH-1:0] alu_res, alu_hi;
  logic             alu_c, alu_v, flags_en;

`ifdef ULA_MUL_EN
  logic [2*WIDTH-1:0] p_q, p_next;
  logic [WIDTH:0]     psum;
  logic [WIDTH-1:0]   hi_q;
`endif

  assign accept    = in_valid && (state_q == StIdle);
  assign last      = (cnt_q == '0);
  assign is_var_in = (seletor == OpShlV) || (seletor == OpShrV);
`ifdef ULA_MUL_EN
  assign is_mul_in = (seletor == OpMul);
`else
  assign is_mul_in = 1'b0;
`endif
  // Shift amount 0 loads 0 and so completes after the single EXEC cycle.
  assign cnt_load = is_mul_in ? CW'(WIDTH) :
                    is_var_in ? CW'(B[SW-1:0]) : '0;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid) state_d = StExec;
      StExec:  if (last) state_d = StDone;
      StDone:  if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

`ifdef ULA_MUL_EN
  // One shift-add step: conditionally add A into the high half, shift right.
  always_comb begin
    psum   = {1'b0, p_q[2*WIDTH-1:WIDTH]} + {1'b0, (p_q[0] ? a_q : '0)};
    p_next = {psum, p_q[WIDTH-1:1]};
  end
`endif

  // Final result selection from captured operands and iteration registers.
  always_comb begin
    alu_res  = '0;
    alu_hi   = '0;
    alu_c    = 1'b0;
    alu_v    = 1'b0;
    flags_en = 1'b1;
    sum      = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    diff     = {1'b0, a_q} - {1'b0, b_q};
    case (op_q)
      OpAnd:  alu_res = a_q & b_q;
      OpOr:   alu_res = a_q | b_q;
      OpNot:  alu_res = ~a_q;
      OpNand: alu_res = ~(a_q & b_q);
      OpXor:  alu_res = a_q ^ b_q;
      OpAdd: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpSub: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];  // borrow
        alu_v   = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (diff[WIDTH-1] != a_q[WIDTH-1]);
      end
      OpShl1: begin
        alu_res = {a_q[WIDTH-2:0], 1'b0};
        alu_c   = a_q[WIDTH-1];
      end
      OpShr1: begin
        alu_res = {1'b0, a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OpSra1: begin
        alu_res = {a_q[WIDTH-1], a_q[WIDTH-1:1]};
        alu_c   = a_q[0];
      end
      OpShlV, OpShrV: begin
        alu_res = sh_q;
        alu_c   = shc_q;
      end
`ifdef ULA_MUL_EN
      OpMul: begin
        alu_res = p_q[WIDTH-1:0];
        alu_hi  = p_q[2*WIDTH-1:WIDTH];
      end
`endif
      default: flags_en = 1'b0;
    endcase
  end

  // Operand capture, iteration steps and result/flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      op_q   <= '0;
      cnt_q  <= '0;
      sh_q   <= '0;
      shc_q  <= 1'b0;
      res_q  <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
`ifdef ULA_MUL_EN
      p_q    <= '0;
      hi_q   <= '0;
`endif
    end else if (accept) begin
      a_q   <= A;
      b_q   <= B;
      cin_q <= Cin;
      op_q  <= seletor;
      cnt_q <= cnt_load;
      sh_q  <= A;
      shc_q <= 1'b0;
`ifdef ULA_MUL_EN
      p_q   <= {{WIDTH{1'b0}}, B};
`endif
    end else if (state_q == StExec) begin
      if (!last) begin
        cnt_q <= cnt_q - CW'(1);
        if (op_q == OpShlV) begin
          sh_q  <= {sh_q[WIDTH-2:0], 1'b0};
          shc_q <= sh_q[WIDTH-1];
        end else if (op_q == OpShrV) begin
          sh_q  <= {1'b0, sh_q[WIDTH-1:1]};
          shc_q <= sh_q[0];
        end
`ifdef ULA_MUL_EN
        if (op_q == OpMul) p_q <= p_next;
`endif
      end else begin
        res_q  <= alu_res;
        cout_q <= alu_c;
        ovf_q  <= alu_v;
        zero_q <= flags_en && (alu_res == '0) && (alu_hi == '0);
        neg_q  <= flags_en && ((op_q == OpMul) ? alu_hi[WIDTH-1] : alu_res[WIDTH-1]);
`ifdef ULA_MUL_EN
        hi_q   <= alu_hi;
`endif
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign resultado = res_q;
  assign Cout      = cout_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign ovf       = ovf_q;
`ifdef ULA_MUL_EN
  assign resultado_hi = hi_q;
`else
  assign resultado_hi = '0;
`endif

endmodule
